// File: rtl/mux4_arbiter.sv
// Two-requester round-robin arbiter with a registered 2:1 data select stage.
// Latency: one cycle from sampled REQ/I to GNT/S/Y/VALID; the hold limit caps a contended grant at MAX_HOLD cycles.
module mux4_arbiter #(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             REQ0,
    input  logic             REQ1,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    output logic             GNT0,
    output logic             GNT1,
    output logic             S,
    output logic [WIDTH-1:0] Y,
    output logic             VALID
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT0 = 2'd1;
    localparam logic [1:0] ST_GRANT1 = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             last_q, last_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             valid_q, valid_d;
    logic             s_q, s_d;
    logic [WIDTH-1:0] y_q, y_d;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        hold_d  = hold_q;

        case (state_q)
            ST_IDLE: begin
                // On a tie the requester that did not own the bus last wins.
                if (REQ0 && REQ1)  state_d = last_q ? ST_GRANT0 : ST_GRANT1;
                else if (REQ0)     state_d = ST_GRANT0;
                else if (REQ1)     state_d = ST_GRANT1;
            end
            ST_GRANT0: begin
                if (REQ0) begin
                    if (REQ1 && (hold_q == HOLD_MAX)) state_d = ST_GRANT1;
                end else if (REQ1) begin
                    state_d = ST_GRANT1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT1: begin
                if (REQ1) begin
                    if (REQ0 && (hold_q == HOLD_MAX)) state_d = ST_GRANT0;
                end else if (REQ0) begin
                    state_d = ST_GRANT0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_IDLE) begin
            hold_d = '0;
        end else if (state_d != state_q) begin
            hold_d = HOLD_ONE;
            last_d = (state_d == ST_GRANT1);
        end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + HOLD_ONE;
        end

        gnt0_d  = (state_d == ST_GRANT0);
        gnt1_d  = (state_d == ST_GRANT1);
        valid_d = gnt0_d | gnt1_d;

        // Select is sticky through IDLE so the downstream mux does not toggle needlessly.
        s_d = gnt1_d ? 1'b1 : (gnt0_d ? 1'b0 : s_q);
        y_d = gnt0_d ? I0 : (gnt1_d ? I1 : '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            hold_q  <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            valid_q <= 1'b0;
            s_q     <= 1'b0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            valid_q <= valid_d;
            s_q     <= s_d;
            y_q     <= y_d;
        end
    end

    assign GNT0  = gnt0_q;
    assign GNT1  = gnt1_q;
    assign VALID = valid_q;
    assign S     = s_q;
    assign Y     = y_q;

endmodule

// File: tb/tb_mux4_arbiter.sv
// Bench for mux4_arbiter: directed vector table, hold-limit sequences, and random traffic vs an owner/run-length model.
module tb_mux4_arbiter;

    localparam int MAXH = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       REQ0 = 1'b0, REQ1 = 1'b0;
    logic [3:0] I0 = 4'h0, I1 = 4'h0;
    logic       GNT0, GNT1, S, VALID;
    logic [3:0] Y;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux4_arbiter #(.WIDTH(4), .MAX_HOLD(MAXH)) dut (
        .clk(clk), .reset(reset), .REQ0(REQ0), .REQ1(REQ1), .I0(I0), .I1(I1),
        .GNT0(GNT0), .GNT1(GNT1), .S(S), .Y(Y), .VALID(VALID)
    );

    // Model: owner -1 = nobody, run = consecutive cycles the current owner has held the bus.
    int         m_owner = -1;
    int         m_run   = 0;
    int         m_last  = 1;
    logic       m_s     = 1'b0;
    logic [3:0] m_y     = 4'h0;

    function automatic void model_update(logic rst, logic r0, logic r1, logic [3:0] d0, logic [3:0] d1);
        int  nxt;
        bit  req[2];
        if (rst) begin
            m_owner = -1; m_run = 0; m_last = 1; m_s = 1'b0; m_y = 4'h0;
            return;
        end
        req[0] = r0; req[1] = r1;
        if (m_owner < 0)              nxt = (r0 && r1) ? 1 - m_last : (r0 ? 0 : (r1 ? 1 : -1));
        else if (req[m_owner])        nxt = (req[1 - m_owner] && m_run >= MAXH) ? 1 - m_owner : m_owner;
        else                          nxt = req[1 - m_owner] ? 1 - m_owner : -1;
        if (nxt < 0)                  m_run = 0;
        else if (nxt == m_owner)      m_run = m_run + 1;
        else begin m_run = 1; m_last = nxt; end
        m_owner = nxt;
        m_y = (nxt == 0) ? d0 : ((nxt == 1) ? d1 : 4'h0);
        if (nxt >= 0) m_s = (nxt == 1);
    endfunction

    function automatic logic [7:0] model_out();
        return {m_owner == 0, m_owner == 1, m_s, m_y, m_owner >= 0};
    endfunction

    function automatic logic [7:0] dut_out();
        return {GNT0, GNT1, S, Y, VALID};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic r0, input logic r1, input logic [3:0] d0, input logic [3:0] d1);
        @(negedge clk);
        reset = rst; REQ0 = r0; REQ1 = r1; I0 = d0; I1 = d1;
        @(posedge clk);
        #1;
        model_update(rst, r0, r1, d0, d1);
    endtask

    typedef struct {
        logic       rst, r0, r1;
        logic [3:0] i0, i1;
        logic [7:0] exp;  // {GNT0, GNT1, S, Y[3:0], VALID}
    } vec_t;

    function automatic vec_t mk(logic rst, logic r0, logic r1, logic [3:0] i0, logic [3:0] i1,
                                logic g0, logic g1, logic s, logic [3:0] y, logic v);
        vec_t t;
        t.rst = rst; t.r0 = r0; t.r1 = r1; t.i0 = i0; t.i1 = i1;
        t.exp = {g0, g1, s, y, v};
        return t;
    endfunction

    vec_t vecs[19];

    initial begin
        vecs[0]  = mk(1, 1, 1, 4'hA, 4'h0,  0, 0, 0, 4'h0, 0);
        vecs[1]  = mk(1, 1, 1, 4'hA, 4'h0,  0, 0, 0, 4'h0, 0);
        vecs[2]  = mk(0, 1, 1, 4'hA, 4'h0,  1, 0, 0, 4'hA, 1);
        vecs[3]  = mk(1, 0, 0, 4'h0, 4'h0,  0, 0, 0, 4'h0, 0);
        vecs[4]  = mk(0, 0, 1, 4'h0, 4'h3,  0, 1, 1, 4'h3, 1);
        vecs[5]  = mk(0, 0, 1, 4'h0, 4'h5,  0, 1, 1, 4'h5, 1);
        vecs[6]  = mk(0, 0, 1, 4'h0, 4'h7,  0, 1, 1, 4'h7, 1);
        vecs[7]  = mk(0, 0, 0, 4'h0, 4'h7,  0, 0, 1, 4'h0, 0);
        vecs[8]  = mk(1, 0, 0, 4'h0, 4'h0,  0, 0, 0, 4'h0, 0);
        vecs[9]  = mk(0, 1, 1, 4'h1, 4'h2,  1, 0, 0, 4'h1, 1);
        vecs[10] = mk(0, 1, 1, 4'h3, 4'h2,  1, 0, 0, 4'h3, 1);
        vecs[11] = mk(0, 0, 1, 4'h3, 4'h4,  0, 1, 1, 4'h4, 1);
        vecs[12] = mk(0, 0, 0, 4'h3, 4'h4,  0, 0, 1, 4'h0, 0);
        vecs[13] = mk(0, 1, 1, 4'h6, 4'h9,  1, 0, 0, 4'h6, 1);
        vecs[14] = mk(0, 0, 0, 4'h6, 4'h9,  0, 0, 0, 4'h0, 0);
        vecs[15] = mk(0, 0, 1, 4'h0, 4'hF,  0, 1, 1, 4'hF, 1);
        vecs[16] = mk(1, 1, 1, 4'h0, 4'hF,  0, 0, 0, 4'h0, 0);
        vecs[17] = mk(0, 1, 1, 4'hC, 4'hF,  1, 0, 0, 4'hC, 1);
        vecs[18] = mk(0, 0, 0, 4'hC, 4'hF,  0, 0, 0, 4'h0, 0);

        foreach (vecs[k]) begin
            step(vecs[k].rst, vecs[k].r0, vecs[k].r1, vecs[k].i0, vecs[k].i1);
            chk($sformatf("vec%0d {g0,g1,s,y,v}", k), 32'(dut_out()), 32'(vecs[k].exp));
        end

        // Continuous contention: ownership alternates every MAX_HOLD cycles.
        step(1, 0, 0, 4'h0, 4'h0);
        for (int k = 0; k < 5 * MAXH; k++) begin
            step(0, 1, 1, 4'($urandom), 4'($urandom));
            chk($sformatf("hold_gnt0 c%0d", k), 32'(GNT0), 32'(((k / MAXH) % 2) == 0));
            chk($sformatf("hold_gnt1 c%0d", k), 32'(GNT1), 32'(((k / MAXH) % 2) == 1));
        end

        // Uncontended grant runs past MAX_HOLD, then yields on the edge after REQ1 rises.
        step(1, 0, 0, 4'h0, 4'h0);
        for (int k = 0; k < 20; k++) begin
            step(0, 1, 0, 4'(k), 4'h0);
            chk($sformatf("solo_gnt0 c%0d", k), 32'({GNT0, GNT1, Y}), 32'({2'b10, 4'(k)}));
        end
        step(0, 1, 1, 4'h1, 4'hB);
        chk("solo_switch", 32'({GNT0, GNT1, S, Y}), 32'({3'b011, 4'hB}));

        // Random traffic against the model.
        step(1, 0, 0, 4'h0, 4'h0);
        for (int k = 0; k < 3000; k++) begin
            logic rr, q0, q1;
            rr = ($urandom_range(0, 79) == 0);
            q0 = ($urandom_range(0, 3) != 0);
            q1 = ($urandom_range(0, 3) != 0);
            step(rr, q0, q1, 4'($urandom), 4'($urandom));
            chk($sformatf("rand c%0d", k), 32'(dut_out()), 32'(model_out()));
            chk($sformatf("rand_excl c%0d", k), 32'(GNT0 & GNT1), 32'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
